uart_rx_frame_sr: RTL and testbench
===================================

Name: uart_rx_frame_sr

Overview:
- Parametrised receive-side framing shift register for the UART receiver datapath; successor to the fixed 8-data/1-stop receive shift register.
- Captures one serial frame of configurable data width, optional parity and 1–2 stop bits, one bit per `shift_strobe`, counting bits itself.
- Flags frame completion, parity error and framing error to the receiver controller and RX FIFO.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9)
- PARITY_EN, 1, 1 = frame carries a parity bit after the data
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected
- STOP_BITS, 1, number of stop bits (1 or 2)
- Derived: FRAME_W = DATA_BITS + PARITY_EN + STOP_BITS
- Derived: CNT_W = $clog2(FRAME_W+1)

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  synchronous active-low reset, sampled on rising clk
- serial_in  in  1  synchronised serial line, already sampled mid-bit
- shift_strobe  in  1  one-cycle pulse: shift serial_in in on this edge
- frame_start  in  1  one-cycle pulse: start-bit detected, arm a new frame
- packet_data  out  DATA_BITS  received data, LSB = first bit received
- parity_bit  out  1  received parity bit (0 when PARITY_EN=0)
- stop_bits  out  STOP_BITS  received stop bit(s)
- bit_count  out  CNT_W  bits captured in the current frame
- frame_done  out  1  one-cycle pulse when the last frame bit is captured
- parity_error  out  1  sticky until next frame_start or reset
- framing_error  out  1  sticky until next frame_start or reset

Behaviour:
- Reset: sr = all ones, so packet_data = all ones, parity_bit = 1 (0 if PARITY_EN=0) and stop_bits = all ones.
- Reset also forces state IDLE, bit_count = 0, frame_done = 0, parity_error = 0, framing_error = 0.
- Reset mid-frame aborts the frame with no frame_done.
- Shift register FRAME_W bits wide. On an accepted strobe, sr <= {serial_in, sr[FRAME_W-1:1]}: right shift, new bit enters at the MSB.
- After FRAME_W accepted strobes, the register holds:
  - sr[DATA_BITS-1:0] = data
  - next bit up = parity
  - top STOP_BITS bits = stops
- Outputs are continuously driven from sr; no bypass of serial_in.
- FSM states:
  - IDLE: strobes ignored, sr holds. frame_start -> SHIFT, bit_count <= 0.
  - SHIFT: each strobe shifts and increments bit_count. The strobe that makes bit_count = FRAME_W -> DONE.
  - DONE: strobes ignored, sr and flags hold. frame_start -> SHIFT, bit_count <= 0.
- frame_start in any state clears bit_count and both error flags. sr is not cleared; data is overwritten by shifting.
- frame_start and shift_strobe in the same cycle: frame_start wins and the strobe is dropped.
- Frame completion, on the edge that captures the last bit (one-cycle latency from that strobe):
  - frame_done <= 1 for exactly one cycle.
  - parity_error <= PARITY_EN & (^{data, parity} != PARITY_ODD), computed on the post-shift value.
  - framing_error <= ~&stop_bits, computed on the post-shift value.
- Gaps of any length between strobes are legal; sr and bit_count hold during gaps.
- bit_count saturates at FRAME_W.

Decomposition:
- Package uart_rx_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} rx_sr_state_t
  - parity function calc_parity(data, odd)
- Sub-module: flex_stp_sr (NUM_BITS = FRAME_W, SHIFT_MSB = 0, reset value all ones, shift_enable = accepted strobe).
- FSM, counter and flag logic live in uart_rx_frame_sr.

Test Plan:
- All tests use defaults (8 data, even parity, 1 stop) unless noted.
- Reset: serial_in = 0, n_rst = 0 for 2 edges -> packet_data = 8'hFF, parity_bit = 1, stop_bits = 1, frame_done = 0, flags 0; values held over an extra clock in reset and after release.
- Contiguous frame: frame_start, then 10 back-to-back strobes with bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> packet_data = 8'hA5, bit_count = 10, frame_done high exactly one cycle after the 10th strobe edge, both flags 0.
- Discontiguous frame: same bits with 2 idle cycles between strobes -> sr and bit_count unchanged during each gap; final result identical to the contiguous frame.
- Errors: frame 8'hA5 with parity 1, stop 0 -> parity_error = 1 and framing_error = 1, held through 5 idle cycles; next frame_start clears both.
- Restart: after 4 strobes, frame_start together with a strobe -> bit_count = 0, that strobe dropped; the next 10 strobes of 8'h3C, parity 0, stop 1 -> packet_data = 8'h3C, no errors.
- Mid-frame reset: n_rst = 0 for one edge after 5 strobes -> all reset values, no frame_done. Then with STOP_BITS = 2: frame 8'h00, parity 0, stops 1,0 -> framing_error = 1, stop_bits = 2'b01.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type and parity helper for the UART receive datapath
package uart_rx_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} rx_sr_state_t;

  // High when the XOR of all bits in data disagrees with the expected sense (odd = 1)
  function automatic logic calc_parity(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// rtl/flex_stp_sr.sv - serial-to-parallel shift register, resets to all ones
module flex_stp_sr #(
  parameter int NUM_BITS  = 4,
  parameter int SHIFT_MSB = 1
) (
  input  logic                i_clk,
  input  logic                i_n_rst,
  input  logic                i_shift_enable,
  input  logic                i_serial_in,
  output logic [NUM_BITS-1:0] o_parallel_out
);

  logic [NUM_BITS-1:0] r_q;
  logic [NUM_BITS-1:0] w_q_next;

  generate
    if (SHIFT_MSB != 0) begin : g_shift_left
      assign w_q_next = {r_q[NUM_BITS-2:0], i_serial_in};
    end else begin : g_shift_right
      assign w_q_next = {i_serial_in, r_q[NUM_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_q <= '1;
    end else if (i_shift_enable) begin
      r_q <= w_q_next;
    end
  end

  assign o_parallel_out = r_q;

endmodule

// File: rtl/uart_rx_frame_sr.sv
// rtl/uart_rx_frame_sr.sv - UART receive framing shift register with bit counter and error flags
module uart_rx_frame_sr
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  localparam int FRAME_W   = DATA_BITS + PARITY_EN + STOP_BITS,
  localparam int CNT_W     = $clog2(FRAME_W + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 shift_strobe,
  input  logic                 frame_start,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 parity_bit,
  output logic [STOP_BITS-1:0] stop_bits,
  output logic [CNT_W-1:0]     bit_count,
  output logic                 frame_done,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

  rx_sr_state_t       r_state;
  rx_sr_state_t       w_next_state;
  logic [CNT_W-1:0]   r_bit_count;
  logic               r_frame_done;
  logic               r_parity_error;
  logic               r_framing_error;
  logic [FRAME_W-1:0] w_sr;
  logic [FRAME_W-1:0] w_sr_next;
  logic               w_accept;
  logic               w_last;
  logic               w_par_err;
  logic               w_frm_err;

  // frame_start takes priority: a strobe arriving with it is dropped
  assign w_accept = (r_state == SHIFT) && shift_strobe && !frame_start
                    && (r_bit_count != FRAME_CNT);
  assign w_last   = w_accept && (r_bit_count == FRAME_CNT - 1'b1);

  flex_stp_sr #(
    .NUM_BITS  (FRAME_W),
    .SHIFT_MSB (0)
  ) u_sr (
    .i_clk          (clk),
    .i_n_rst        (n_rst),
    .i_shift_enable (w_accept),
    .i_serial_in    (serial_in),
    .o_parallel_out (w_sr)
  );

  // Errors are judged on the value the register holds after the final shift
  assign w_sr_next = {serial_in, w_sr[FRAME_W-1:1]};
  assign w_frm_err = ~&w_sr_next[FRAME_W-1 -: STOP_BITS];

  generate
    if (PARITY_EN != 0) begin : g_par
      assign parity_bit = w_sr[DATA_BITS];
      assign w_par_err  = calc_parity(16'(w_sr_next[DATA_BITS:0]), PARITY_ODD != 0);
    end else begin : g_nopar
      assign parity_bit = 1'b0;
      assign w_par_err  = 1'b0;
    end
  endgenerate

  always_comb begin
    w_next_state = r_state;
    if (frame_start) begin
      w_next_state = SHIFT;
    end else if (w_last) begin
      w_next_state = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state         <= IDLE;
      r_bit_count     <= '0;
      r_frame_done    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_frame_done <= w_last;
      if (frame_start) begin
        r_bit_count     <= '0;
        r_parity_error  <= 1'b0;
        r_framing_error <= 1'b0;
      end else if (w_accept) begin
        r_bit_count <= r_bit_count + 1'b1;
        if (w_last) begin
          r_parity_error  <= w_par_err;
          r_framing_error <= w_frm_err;
        end
      end
    end
  end

  assign packet_data   = w_sr[DATA_BITS-1:0];
  assign stop_bits     = w_sr[FRAME_W-1 -: STOP_BITS];
  assign bit_count     = r_bit_count;
  assign frame_done    = r_frame_done;
  assign parity_error  = r_parity_error;
  assign framing_error = r_framing_error;

endmodule

// File: tb/tb_uart_rx_frame_sr.sv
// tb/tb_uart_rx_frame_sr.sv - directed self-checking bench for uart_rx_frame_sr
module tb_uart_rx_frame_sr;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       n_rst2;
  logic       serial_in;
  logic       shift_strobe;
  logic       frame_start;

  logic [7:0] packet_data;
  logic       parity_bit;
  logic [0:0] stop_bits;
  logic [3:0] bit_count;
  logic       frame_done;
  logic       parity_error;
  logic       framing_error;

  logic [7:0] packet_data2;
  logic       parity_bit2;
  logic [1:0] stop_bits2;
  logic [3:0] bit_count2;
  logic       frame_done2;
  logic       parity_error2;
  logic       framing_error2;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_sr;

  always #5 clk = ~clk;

  uart_rx_frame_sr dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .shift_strobe  (shift_strobe),
    .frame_start   (frame_start),
    .packet_data   (packet_data),
    .parity_bit    (parity_bit),
    .stop_bits     (stop_bits),
    .bit_count     (bit_count),
    .frame_done    (frame_done),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  uart_rx_frame_sr #(.STOP_BITS(2)) dut2 (
    .clk           (clk),
    .n_rst         (n_rst2),
    .serial_in     (serial_in),
    .shift_strobe  (shift_strobe),
    .frame_start   (frame_start),
    .packet_data   (packet_data2),
    .parity_bit    (parity_bit2),
    .stop_bits     (stop_bits2),
    .bit_count     (bit_count2),
    .frame_done    (frame_done2),
    .parity_error  (parity_error2),
    .framing_error (framing_error2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic cyc(input logic sin, input logic strobe, input logic start);
    serial_in    = sin;
    shift_strobe = strobe;
    frame_start  = start;
    @(posedge clk);
    #1;
    shift_strobe = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(bits[i], 1'b1, 1'b0);
      if (i < n - 1) chk({tag, "_done_early"}, frame_done | frame_done2, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},   packet_data,   8'hFF);
    chk({tag, "_par"},    parity_bit,    1);
    chk({tag, "_stop"},   stop_bits,     1);
    chk({tag, "_cnt"},    bit_count,     0);
    chk({tag, "_done"},   frame_done,    0);
    chk({tag, "_perr"},   parity_error,  0);
    chk({tag, "_ferr"},   framing_error, 0);
  endtask

  initial begin
    n_rst = 1'b0; n_rst2 = 1'b0;
    serial_in = 1'b0; shift_strobe = 1'b0; frame_start = 1'b0;

    // Reset
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_reset_vals("rst");
    chk("rst2_stop", stop_bits2, 2'b11);
    cyc(1'b0, 1'b1, 1'b0);
    chk_reset_vals("rst_hold");
    n_rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    chk_reset_vals("rst_rel");

    // Contiguous frame A5, parity 0, stop 1
    cyc(1'b0, 1'b0, 1'b1);
    chk("c_start_cnt", bit_count, 0);
    send_frame(16'h02A5, 10, "c");
    chk("c_data", packet_data, 8'hA5);
    chk("c_par", parity_bit, 0);
    chk("c_stop", stop_bits, 1);
    chk("c_cnt", bit_count, 10);
    chk("c_done", frame_done, 1);
    chk("c_perr", parity_error, 0);
    chk("c_ferr", framing_error, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("c_done_pulse", frame_done, 0);
    chk("c_sat_cnt", bit_count, 10);
    chk("c_sat_data", packet_data, 8'hA5);

    // Discontiguous frame: 2 idle cycles between strobes
    cyc(1'b0, 1'b0, 1'b1);
    exp_sr = 10'h2A5;
    begin
      logic [9:0] bits;
      logic [9:0] mdl;
      bits = 10'h2A5;
      mdl  = {2'b10, 8'hA5};
      for (int i = 0; i < 10; i++) begin
        cyc(bits[i], 1'b1, 1'b0);
        mdl = {bits[i], mdl[9:1]};
        for (int g = 0; g < 2; g++) begin
          if (i < 9) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("d_gap_cnt", bit_count, i + 1);
            chk("d_gap_data", packet_data, mdl[7:0]);
          end
        end
      end
      chk("d_model", mdl, exp_sr);
    end
    chk("d_data", packet_data, 8'hA5);
    chk("d_cnt", bit_count, 10);
    chk("d_done", frame_done, 1);
    chk("d_perr", parity_error, 0);
    chk("d_ferr", framing_error, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("d_done_pulse", frame_done, 0);

    // Errors: A5 with parity 1, stop 0
    cyc(1'b0, 1'b0, 1'b1);
    send_frame(16'h01A5, 10, "e");
    chk("e_data", packet_data, 8'hA5);
    chk("e_par", parity_bit, 1);
    chk("e_stop", stop_bits, 0);
    chk("e_done", frame_done, 1);
    chk("e_perr", parity_error, 1);
    chk("e_ferr", framing_error, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("e_hold_perr", parity_error, 1);
      chk("e_hold_ferr", framing_error, 1);
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("e_clr_perr", parity_error, 0);
    chk("e_clr_ferr", framing_error, 0);
    chk("e_clr_cnt", bit_count, 0);

    // Restart: frame_start together with a strobe after 4 strobes
    send_frame(16'h000F, 4, "r");
    chk("r_cnt4", bit_count, 4);
    cyc(1'b0, 1'b1, 1'b1);
    chk("r_cnt0", bit_count, 0);
    send_frame(16'h023C, 10, "r2");
    chk("r_data", packet_data, 8'h3C);
    chk("r_cnt", bit_count, 10);
    chk("r_done", frame_done, 1);
    chk("r_perr", parity_error, 0);
    chk("r_ferr", framing_error, 0);

    // Mid-frame reset after 5 strobes
    cyc(1'b0, 1'b0, 1'b1);
    send_frame(16'h0000, 5, "m");
    chk("m_cnt5", bit_count, 5);
    n_rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    chk_reset_vals("m_rst");
    n_rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("m_no_done", frame_done, 0);
    end
    chk("m_data_idle", packet_data, 8'hFF);

    // Two stop bits: data 00, parity 0, stops 1 then 0
    n_rst2 = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      logic [10:0] b2;
      b2 = 11'h200;
      cyc(b2[i], 1'b1, 1'b0);
      if (i < 10) chk("s2_done_early", frame_done2, 0);
    end
    chk("s2_data", packet_data2, 8'h00);
    chk("s2_par", parity_bit2, 0);
    chk("s2_stop", stop_bits2, 2'b01);
    chk("s2_cnt", bit_count2, 11);
    chk("s2_done", frame_done2, 1);
    chk("s2_perr", parity_error2, 0);
    chk("s2_ferr", framing_error2, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("s2_done_pulse", frame_done2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
